// File: rtl/im_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : im_fetch_responder
// Brief    : Item-memory address responder; fixed-latency reads, credit-
//            limited in-order FIFO delivery. Option: IM_FETCH_RESP_ADDR_ECHO_EN
// Revision : 1.0
// ============================================================================
module im_fetch_responder #(
    parameter int unsigned ImAddrWidth  = 10,
    parameter int unsigned HVDimension  = 512,
    parameter int unsigned ReadLatency  = 2,
    parameter int unsigned BufDepth     = ReadLatency + 1,
    parameter int unsigned CsrDataWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [ImAddrWidth-1:0]  addr_i,
    input  logic                    addr_valid_i,
    output logic                    addr_ready_o,
    output logic                    mem_req_o,
    output logic [ImAddrWidth-1:0]  mem_addr_o,
    input  logic [HVDimension-1:0]  mem_rdata_i,
    output logic [HVDimension-1:0]  data_o,
    output logic                    data_valid_o,
    input  logic                    data_ready_i,
    output logic                    busy_o,
`ifdef IM_FETCH_RESP_ADDR_ECHO_EN
    output logic [ImAddrWidth-1:0]  data_addr_o,
`endif
    output logic [CsrDataWidth-1:0] word_count_o
);

    localparam int unsigned PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned CntW = $clog2(BufDepth + 1);
    localparam int unsigned OutW = $clog2(BufDepth + ReadLatency + 1);

    logic [ReadLatency-1:0]  vld_q;
    logic [ReadLatency-1:0]  vld_d;
    logic [HVDimension-1:0]  buf_q [BufDepth];
    logic [PtrW-1:0]         wptr_q;
    logic [PtrW-1:0]         rptr_q;
    logic [CntW-1:0]         cnt_q;
    logic [CsrDataWidth-1:0] words_q;
    logic [OutW-1:0]         outstanding;

    logic flush;
    logic push;
    logic pop;
    logic accept;
    logic empty;
    logic full;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BufDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign flush = ~en_i | clr_i;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntW'(BufDepth));
    assign pop   = ~empty & data_ready_i;
    assign push  = vld_q[ReadLatency-1];

    // Credits cover both reads in flight and words already buffered.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < ReadLatency; i++) begin
            outstanding = outstanding + OutW'(vld_q[i]);
        end
        outstanding = outstanding + OutW'(cnt_q);
    end

    assign addr_ready_o = en_i & ~clr_i & ((outstanding < OutW'(BufDepth)) | pop);
    assign accept       = addr_valid_i & addr_ready_o;
    assign mem_req_o    = accept;
    assign mem_addr_o   = addr_i;
    assign vld_d        = (vld_q << 1) | ReadLatency'(accept);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            for (int i = 0; i < BufDepth; i++) begin
                buf_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (push) begin
                buf_q[wptr_q] <= mem_rdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q  <= ptr_inc(rptr_q);
                words_q <= words_q + CsrDataWidth'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o       = buf_q[rptr_q];
    assign data_valid_o = ~empty;
    assign busy_o       = (|vld_q) | ~empty;
    assign word_count_o = words_q;

`ifdef IM_FETCH_RESP_ADDR_ECHO_EN
    logic [ImAddrWidth-1:0] apipe_q [ReadLatency];
    logic [ImAddrWidth-1:0] abuf_q  [BufDepth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ReadLatency; i++) begin
                apipe_q[i] <= '0;
            end
            for (int i = 0; i < BufDepth; i++) begin
                abuf_q[i] <= '0;
            end
        end else begin
            apipe_q[0] <= addr_i;
            for (int i = 1; i < ReadLatency; i++) begin
                apipe_q[i] <= apipe_q[i-1];
            end
            if (push && !flush) begin
                abuf_q[wptr_q] <= apipe_q[ReadLatency-1];
            end
        end
    end

    assign data_addr_o = abuf_q[rptr_q];
`endif

    // The credit rule must make a push into a full, non-draining FIFO impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_fetch_responder
// Brief    : Self-checking bench: vector tables, corner sequences and a
//            randomized run against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_im_fetch_responder;

    localparam int AW = 10;
    localparam int HV = 512;
    localparam int RL = 2;
    localparam int BD = 3;
    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          clr_i;
    logic [AW-1:0] addr_i;
    logic          addr_valid_i;
    logic          addr_ready_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [HV-1:0] mem_rdata_i;
    logic [HV-1:0] data_o;
    logic          data_valid_o;
    logic          data_ready_i;
    logic          busy_o;
    logic [CW-1:0] word_count_o;
`ifdef IM_FETCH_RESP_ADDR_ECHO_EN
    logic [AW-1:0] data_addr_o;
`endif

    im_fetch_responder #(
        .ImAddrWidth (AW),
        .HVDimension (HV),
        .ReadLatency (RL),
        .BufDepth    (BD),
        .CsrDataWidth(CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .addr_i      (addr_i),
        .addr_valid_i(addr_valid_i),
        .addr_ready_o(addr_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .busy_o      (busy_o),
`ifdef IM_FETCH_RESP_ADDR_ECHO_EN
        .data_addr_o (data_addr_o),
`endif
        .word_count_o(word_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Item memory: rdata = addr*3, RL cycles after the strobe; noise otherwise.
    logic [HV-1:0] memq [RL];
    always @(posedge clk_i) begin
        for (int i = RL - 1; i > 0; i--) memq[i] <= memq[i-1];
        memq[0] <= mem_req_o ? HV'(mem_addr_o) * HV'(3) : {16{$urandom}};
    end
    assign mem_rdata_i = memq[RL-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted address in order with its accept cycle.
    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } ent_t;
    ent_t    mq[$];
    int      cyc  = 0;
    int      mcnt = 0;

    task automatic drive(input logic en_v, input logic clr_v, input logic av_v,
                         input logic [AW-1:0] a_v, input logic dr_v,
                         output logic o_ardy, output logic o_dv,
                         output logic [HV-1:0] o_data, output logic [CW-1:0] o_cnt);
        logic e_dv, e_pop, e_ardy, e_acc;
        en_i = en_v; clr_i = clr_v; addr_valid_i = av_v; addr_i = a_v; data_ready_i = dr_v;
        #1;
        e_dv   = (mq.size() > 0) && (cyc >= mq[0].cyc + RL + 1);
        e_pop  = e_dv && dr_v;
        e_ardy = en_v && !clr_v && ((mq.size() < BD) || e_pop);
        e_acc  = e_ardy && av_v;
        chk("m_dv", data_valid_o, e_dv);
        chk("m_ardy", addr_ready_o, e_ardy);
        chk("m_req", mem_req_o, e_acc);
        if (e_acc) chk("m_maddr", mem_addr_o, a_v);
        chk("m_busy", busy_o, mq.size() > 0);
        chk("m_cnt", word_count_o, CW'(mcnt));
        if (e_dv) chk("m_data", data_o, HV'(mq[0].addr) * HV'(3));
`ifdef IM_FETCH_RESP_ADDR_ECHO_EN
        if (e_dv) chk("m_echo", data_addr_o, mq[0].addr);
`endif
        o_ardy = addr_ready_o; o_dv = data_valid_o; o_data = data_o; o_cnt = word_count_o;
        @(posedge clk_i);
        if (!en_v || clr_v) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (e_pop) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (e_acc) mq.push_back('{addr: a_v, cyc: cyc});
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        logic          en, clr, av;
        logic [AW-1:0] addr;
        logic          dr;
        logic          ardy, dv;
        logic [HV-1:0] data;
        logic [CW-1:0] cnt;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        logic ar, dv;
        logic [HV-1:0] d;
        logic [CW-1:0] c;
        drive(v.en, v.clr, v.av, v.addr, v.dr, ar, dv, d, c);
        chk({tag, "_ardy"}, ar, v.ardy);
        chk({tag, "_dv"}, dv, v.dv);
        chk({tag, "_cnt"}, c, v.cnt);
        if (v.dv) chk({tag, "_data"}, d, v.data);
    endtask

    vec_t sv[12];
    vec_t bv[11];

    initial begin
        logic ar, dv;
        logic [HV-1:0] d;
        logic [CW-1:0] c;

        // Stream 0..7 at full rate: data three cycles after each accept.
        for (int r = 0; r < 12; r++) begin
            sv[r] = '{en: 1, clr: 0, av: (r < 8), addr: AW'(r), dr: 1, ardy: 1,
                      dv: (r >= 3 && r <= 10), data: HV'((r - 3) * 3),
                      cnt: CW'((r <= 3) ? 0 : r - 3)};
        end
        // Clear, then backpressure with 5,6,7,8 offered; 8 waits for the first pop.
        bv[0]  = '{1, 1, 0, 0, 1, 0, 0, 0, 8};
        bv[1]  = '{1, 0, 1, 5, 0, 1, 0, 0, 0};
        bv[2]  = '{1, 0, 1, 6, 0, 1, 0, 0, 0};
        bv[3]  = '{1, 0, 1, 7, 0, 1, 0, 0, 0};
        bv[4]  = '{1, 0, 1, 8, 0, 0, 1, 15, 0};
        bv[5]  = '{1, 0, 1, 8, 0, 0, 1, 15, 0};
        bv[6]  = '{1, 0, 1, 8, 1, 1, 1, 15, 0};
        bv[7]  = '{1, 0, 0, 0, 1, 1, 1, 18, 1};
        bv[8]  = '{1, 0, 0, 0, 1, 1, 1, 21, 2};
        bv[9]  = '{1, 0, 0, 0, 1, 1, 1, 24, 3};
        bv[10] = '{1, 0, 0, 0, 1, 1, 0, 0, 4};

        rst_ni = 0; en_i = 0; clr_i = 0; addr_i = '0; addr_valid_i = 0; data_ready_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_dv", data_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ardy", addr_ready_o, 0);
        chk("rst_cnt", word_count_o, 0);
        chk("rst_req", mem_req_o, 0);
        rst_ni = 1;

        drive(1, 0, 0, 0, 1, ar, dv, d, c);
        for (int i = 0; i < 12; i++) run_vec(sv[i], "stream");
        for (int i = 0; i < 11; i++) run_vec(bv[i], "bp");

        // Clear one cycle after two accepts: both returns must vanish.
        drive(1, 0, 1, 10, 1, ar, dv, d, c);
        drive(1, 0, 1, 11, 1, ar, dv, d, c);
        drive(1, 1, 0, 0, 1, ar, dv, d, c);
        chk("clr_ardy_during", ar, 0);
        chk("clr_busy_after", busy_o, 0);
        chk("clr_cnt_after", word_count_o, 0);
        drive(1, 0, 0, 0, 1, ar, dv, d, c);
        chk("clr_ardy_next", ar, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1, ar, dv, d, c);
            chk("clr_no_dv", dv, 0);
        end

        // Disable with two words buffered.
        drive(1, 0, 1, 1, 0, ar, dv, d, c);
        drive(1, 0, 1, 2, 0, ar, dv, d, c);
        drive(1, 0, 0, 0, 0, ar, dv, d, c);
        drive(1, 0, 0, 0, 0, ar, dv, d, c);
        drive(0, 0, 1, 3, 0, ar, dv, d, c);
        chk("dis_dv_still", dv, 1);
        chk("dis_ardy", ar, 0);
        drive(0, 0, 0, 0, 0, ar, dv, d, c);
        chk("dis_dv_next", dv, 0);
        chk("dis_ardy_next", ar, 0);

        // Async reset between edges with reads in flight; late returns ignored.
        drive(1, 0, 1, 4, 1, ar, dv, d, c);
        drive(1, 0, 1, 5, 1, ar, dv, d, c);
        addr_valid_i = 0;
        #2 rst_ni = 0;
        #1;
        chk("arst_dv", data_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_cnt", word_count_o, 0);
        chk("arst_data", data_o, 0);
`ifdef IM_FETCH_RESP_ADDR_ECHO_EN
        chk("arst_echo", data_addr_o, 0);
`endif
        mq.delete();
        mcnt = 0;
        #1 rst_ni = 1;
        @(posedge clk_i);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1, ar, dv, d, c);
            chk("arst_stale", dv, 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 31) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 9) < 6,
                  ar, dv, d, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
